// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the fetch/decode instruction queue.
// Optional feature macro: FDQ_BYPASS_EN (combinational in->out bypass when empty).
package fetch_decode_queue_pkg;

    localparam int FDQ_DEPTH_DEFAULT = 8;
    localparam int FDQ_LANES_DEFAULT = 2;

    // All-zero instruction word decodes as sll $0,$0,0 (a nop).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ds;
        logic        excp;
    } fdq_entry_t;

    // Value shown on an out lane that holds no entry.
    localparam fdq_entry_t FDQ_ENTRY_EMPTY = '{pc: 32'h0, instr: NOP_INSTR, ds: 1'b0, excp: 1'b0};

endpackage

// File: rtl/fetch_decode_queue_ptr.sv
// fdq_ptr: circular-buffer pointer that advances by N entries per cycle.
// Width PW equals log2(DEPTH), so plain binary overflow gives the wrap.
// Optional feature macro used by the top: FDQ_BYPASS_EN (not referenced here).
module fdq_ptr
    import fetch_decode_queue_pkg::*;
#(
    parameter int PW = 3,
    parameter int NW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [NW-1:0] adv,
    output logic [PW-1:0] ptr
);

    // Pointer register: reset and clear return to slot 0, otherwise advance modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + PW'(adv);
        end
    end

endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: multi-lane FIFO between instruction fetch and decode.
// Optional feature macro: FDQ_BYPASS_EN -- when the queue is empty and not
// flushing, incoming lanes are presented on out_* in the same cycle and any
// lanes consumed by pop_cnt are never written into storage.
// Handshake: a push is taken only when in_ready=1 (derived from registered
// count alone); pop_cnt consumes up to popcount(out_valid) head entries and
// larger requests are clamped.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int DEPTH = FDQ_DEPTH_DEFAULT,
    parameter int LANES = FDQ_LANES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [LANES-1:0]           in_valid,
    input  logic [32*LANES-1:0]        in_pc,
    input  logic [32*LANES-1:0]        in_instr,
    input  logic [LANES-1:0]           in_ds,
    input  logic [LANES-1:0]           in_excp,
    output logic                       in_ready,
    output logic [LANES-1:0]           out_valid,
    output logic [32*LANES-1:0]        out_pc,
    output logic [32*LANES-1:0]        out_pc_plus4,
    output logic [32*LANES-1:0]        out_instr,
    output logic [LANES-1:0]           out_ds,
    output logic [LANES-1:0]           out_excp,
    input  logic [$clog2(LANES+1)-1:0] pop_cnt,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int NW  = $clog2(LANES + 1);

    fdq_entry_t       mem [DEPTH];
    fdq_entry_t       in_ent [LANES];
    fdq_entry_t       out_ent [LANES];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [LANES-1:0] q_valid;
    logic [NW-1:0]    push_n;
    logic [NW-1:0]    avail_n;
    logic [NW-1:0]    pop_n;
    logic [NW-1:0]    skip_n;
    logic             in_valid_ok;
    logic             push_ok;
    logic             byp_active;

    // Room for a full-width push, judged only on registered occupancy.
    assign in_ready = (CW1'(count) + CW1'(LANES)) <= CW1'(DEPTH);

    // Legal valid masks are 0, 1, 3, ...: x & (x+1) is zero only for those.
    assign in_valid_ok = ((in_valid & (in_valid + LANES'(1))) == '0);
    assign push_ok     = in_ready && in_valid_ok && !flush;

`ifdef FDQ_BYPASS_EN
    assign byp_active = (count == '0) && !flush;
`else
    assign byp_active = 1'b0;
`endif

    // Unpack input lanes, count accepted pushes and occupied head slots.
    always_comb begin
        push_n = '0;
        for (int i = 0; i < LANES; i++) begin
            in_ent[i]  = '{pc: in_pc[32*i +: 32], instr: in_instr[32*i +: 32],
                           ds: in_ds[i], excp: in_excp[i]};
            q_valid[i] = (count > CW'(i));
            if (push_ok && in_valid[i]) begin
                push_n = push_n + NW'(1);
            end
        end
    end

    // Head-lane view: bypassed inputs when empty, otherwise stored entries; empty lanes read zero.
    always_comb begin
        avail_n = '0;
        for (int i = 0; i < LANES; i++) begin
            out_valid[i] = 1'b0;
            out_ent[i]   = FDQ_ENTRY_EMPTY;
            if (byp_active) begin
                if (push_ok && in_valid[i]) begin
                    out_valid[i] = 1'b1;
                    out_ent[i]   = in_ent[i];
                end
            end else if (q_valid[i]) begin
                out_valid[i] = 1'b1;
                out_ent[i]   = mem[head + PW'(i)];
            end
            if (out_valid[i]) begin
                avail_n = avail_n + NW'(1);
            end
            out_pc[32*i +: 32]       = out_ent[i].pc;
            out_pc_plus4[32*i +: 32] = out_valid[i] ? (out_ent[i].pc + 32'd4) : 32'h0;
            out_instr[32*i +: 32]    = out_ent[i].instr;
            out_ds[i]                = out_ent[i].ds;
            out_excp[i]              = out_ent[i].excp;
        end
    end

    // Clamp pops to what is visible; bypassed lanes that are consumed skip storage.
    assign pop_n  = (pop_cnt > avail_n) ? avail_n : pop_cnt;
    assign skip_n = byp_active ? pop_n : '0;

    // Entry storage: lane i lands at tail+i; contents are never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (rst && push_ok && in_valid[i] && (NW'(i) >= skip_n)) begin
                mem[tail + PW'(i)] <= in_ent[i];
            end
        end
    end

    // Occupancy: reset and flush empty the queue, otherwise add pushes and remove pops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    fdq_ptr #(.PW(PW), .NW(NW)) u_head (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .adv (pop_n),
        .ptr (head)
    );

    fdq_ptr #(.PW(PW), .NW(NW)) u_tail (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .adv (push_n),
        .ptr (tail)
    );

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed testbench for fetch_decode_queue (DEPTH=8, LANES=2).
// Build with +define+FDQ_BYPASS_EN to also exercise the same-cycle bypass.
module tb_fetch_decode_queue;

    localparam int DEPTH = 8;
    localparam int LANES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_pc;
    logic [63:0] in_instr;
    logic [1:0]  in_ds;
    logic [1:0]  in_excp;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_pc;
    logic [63:0] out_pc_plus4;
    logic [63:0] out_instr;
    logic [1:0]  out_ds;
    logic [1:0]  out_excp;
    logic [1:0]  pop_cnt;
    logic [3:0]  count;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    fetch_decode_queue #(.DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_ds        (in_ds),
        .in_excp      (in_excp),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr),
        .out_ds       (out_ds),
        .out_excp     (out_excp),
        .pop_cnt      (pop_cnt),
        .count        (count)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 2'b00;
        in_pc    = '0;
        in_instr = '0;
        in_ds    = 2'b00;
        in_excp  = 2'b00;
        pop_cnt  = 2'd0;
        flush    = 1'b0;
    endtask

    // Instruction word of each lane is the bitwise inverse of its pc.
    task automatic drive_push(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                              input logic [1:0] ds, input logic [1:0] excp);
        in_valid = v;
        in_pc    = {pc1, pc0};
        in_instr = {~pc1, ~pc0};
        in_ds    = ds;
        in_excp  = excp;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL reset_out_valid got %b want 00", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_instr !== 64'h0) begin n_err++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_push_basic();
        drive_push(2'b11, 32'hBFC0_0000, 32'hBFC0_0004, 2'b00, 2'b00);
        tick();
        drive_idle();
        n_cmp++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL basic_out_valid got %b want 11", out_valid); end
        n_cmp++; if (out_pc_plus4[31:0] !== 32'hBFC0_0004) begin n_err++; $display("FAIL basic_pc4_l0 got %h want bfc00004", out_pc_plus4[31:0]); end
        n_cmp++; if (out_pc_plus4[63:32] !== 32'hBFC0_0008) begin n_err++; $display("FAIL basic_pc4_l1 got %h want bfc00008", out_pc_plus4[63:32]); end
        n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL basic_count got %0d want 2", count); end
        n_cmp++; if (out_instr !== {32'h403F_FFFB, 32'h403F_FFFF}) begin n_err++; $display("FAIL basic_instr got %h want 403ffffb403fffff", out_instr); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL basic_flush_count got %0d want 0", count); end
    endtask

    task automatic test_full();
        drive_push(2'b11, 32'h1000, 32'h1004, 2'b00, 2'b00); tick();
        drive_push(2'b11, 32'h1008, 32'h100C, 2'b00, 2'b00); tick();
        drive_push(2'b11, 32'h1010, 32'h1014, 2'b00, 2'b00); tick();
        drive_push(2'b01, 32'h1018, 32'h0,    2'b00, 2'b00); tick();
        drive_idle();
        n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL full_count got %0d want 7", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        drive_push(2'b11, 32'h2000, 32'h2004, 2'b00, 2'b00); tick();
        drive_idle();
        n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL full_ignored_count got %0d want 7", count); end
        pop_cnt = 2'd2; tick(); pop_cnt = 2'd0;
        n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL full_pop_count got %0d want 5", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_ready got %b want 1", in_ready); end
        n_cmp++; if (out_pc !== {32'h100C, 32'h1008}) begin n_err++; $display("FAIL full_head_pc got %h want 0000100c00001008", out_pc); end
        pop_cnt = 2'd2; tick();
        pop_cnt = 2'd2; tick(); pop_cnt = 2'd0;
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL full_last_count got %0d want 1", count); end
        n_cmp++; if (out_valid !== 2'b01) begin n_err++; $display("FAIL full_last_valid got %b want 01", out_valid); end
        n_cmp++; if (out_pc !== {32'h0, 32'h1018}) begin n_err++; $display("FAIL full_last_pc got %h want 0000000000001018", out_pc); end
        n_cmp++; if (out_instr[63:32] !== 32'h0) begin n_err++; $display("FAIL full_empty_lane_instr got %h want 0", out_instr[63:32]); end
        // Over-pop is clamped to the single visible entry.
        pop_cnt = 2'd2; tick(); pop_cnt = 2'd0;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL full_clamp_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL full_clamp_valid got %b want 00", out_valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] p0;
        drive_push(2'b11, 32'h3000, 32'h3004, 2'b00, 2'b00);
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3004);
        tick();
        for (int k = 0; k < 12; k++) begin
            p0 = 32'h3008 + 32'(8 * k);
            drive_push(2'b11, p0, p0 + 32'd4, 2'b00, 2'b00);
            pop_cnt = 2'd2;
            e0 = exp_q.pop_front();
            e1 = exp_q.pop_front();
            n_cmp++; if (out_pc !== {e1, e0}) begin n_err++; $display("FAIL wrap_pc[%0d] got %h want %h%h", k, out_pc, e1, e0); end
            n_cmp++; if (out_instr[31:0] !== ~e0) begin n_err++; $display("FAIL wrap_instr[%0d] got %h want %h", k, out_instr[31:0], ~e0); end
            exp_q.push_back(p0);
            exp_q.push_back(p0 + 32'd4);
            tick();
            n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want 2", k, count); end
        end
        drive_idle();
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        n_cmp++; if (out_pc !== {e1, e0}) begin n_err++; $display("FAIL wrap_final_pc got %h want %h%h", out_pc, e1, e0); end
        pop_cnt = 2'd2; tick(); pop_cnt = 2'd0;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL wrap_drain_count got %0d want 0", count); end
    endtask

    task automatic test_noncontig();
        drive_push(2'b10, 32'h4000, 32'h4004, 2'b00, 2'b00);
        #1;
        n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL noncontig_valid got %b want 00", out_valid); end
        tick();
        drive_idle();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL noncontig_count got %0d want 0", count); end
    endtask

    task automatic test_flush();
        drive_push(2'b11, 32'h5000, 32'h5004, 2'b00, 2'b00); tick();
        drive_push(2'b11, 32'h5008, 32'h500C, 2'b00, 2'b00); tick();
        drive_idle();
        n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL flush_pre_count got %0d want 4", count); end
        drive_push(2'b11, 32'h6000, 32'h6004, 2'b00, 2'b00);
        pop_cnt = 2'd1;
        flush   = 1'b1;
        tick();
        drive_idle();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL flush_valid got %b want 00", out_valid); end
        n_cmp++; if (out_instr !== 64'h0) begin n_err++; $display("FAIL flush_instr got %h want 0", out_instr); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", in_ready); end
        tick();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_after_count got %0d want 0", count); end
    endtask

    task automatic test_tags();
        drive_push(2'b01, 32'h8000_0000, 32'h0, 2'b00, 2'b00); tick();
        drive_push(2'b11, 32'h8000_0004, 32'h8000_0008, 2'b10, 2'b10); tick();
        drive_idle();
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL tags_count got %0d want 3", count); end
        n_cmp++; if (out_ds !== 2'b00 || out_excp !== 2'b00) begin n_err++; $display("FAIL tags_early got ds=%b excp=%b want 00/00", out_ds, out_excp); end
        pop_cnt = 2'd2; tick(); pop_cnt = 2'd0;
        n_cmp++; if (out_valid !== 2'b01) begin n_err++; $display("FAIL tags_valid got %b want 01", out_valid); end
        n_cmp++; if (out_pc[31:0] !== 32'h8000_0008) begin n_err++; $display("FAIL tags_pc got %h want 80000008", out_pc[31:0]); end
        n_cmp++; if (out_ds !== 2'b01 || out_excp !== 2'b01) begin n_err++; $display("FAIL tags_bits got ds=%b excp=%b want 01/01", out_ds, out_excp); end
        n_cmp++; if (out_pc_plus4[31:0] !== 32'h8000_000C) begin n_err++; $display("FAIL tags_pc4 got %h want 8000000c", out_pc_plus4[31:0]); end
        pop_cnt = 2'd1; tick(); pop_cnt = 2'd0;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL tags_drain got %0d want 0", count); end
    endtask

    task automatic test_pc_wrap();
        drive_push(2'b01, 32'hFFFF_FFFC, 32'h0, 2'b00, 2'b00); tick();
        drive_idle();
        n_cmp++; if (out_pc_plus4[31:0] !== 32'h0) begin n_err++; $display("FAIL pcwrap_pc4 got %h want 0", out_pc_plus4[31:0]); end
        pop_cnt = 2'd1; tick(); pop_cnt = 2'd0;
    endtask

    task automatic test_reset_mid();
        drive_push(2'b11, 32'h9000, 32'h9004, 2'b00, 2'b00); tick();
        drive_push(2'b11, 32'h9008, 32'h900C, 2'b00, 2'b00);
        pop_cnt = 2'd1;
        flush   = 1'b1;
        rst     = 1'b0;
        tick();
        rst = 1'b1;
        drive_idle();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL rstmid_valid got %b want 00", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
    endtask

`ifdef FDQ_BYPASS_EN
    task automatic test_bypass();
        drive_push(2'b11, 32'h7000, 32'h7004, 2'b00, 2'b00);
        pop_cnt = 2'd2;
        #1;
        n_cmp++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL bypass_valid got %b want 11", out_valid); end
        n_cmp++; if (out_pc !== {32'h7004, 32'h7000}) begin n_err++; $display("FAIL bypass_pc got %h want 0000700400007000", out_pc); end
        tick();
        drive_idle();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL bypass_count got %0d want 0", count); end
        drive_push(2'b11, 32'h7008, 32'h700C, 2'b00, 2'b00);
        pop_cnt = 2'd1;
        tick();
        drive_idle();
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL bypass_part_count got %0d want 1", count); end
        n_cmp++; if (out_pc[31:0] !== 32'h700C) begin n_err++; $display("FAIL bypass_part_pc got %h want 700c", out_pc[31:0]); end
        pop_cnt = 2'd1; tick(); pop_cnt = 2'd0;
    endtask
`endif

    initial begin
        rst = 1'b0;
        drive_idle();
        test_reset();
        test_push_basic();
        test_full();
        test_wrap();
        test_noncontig();
        test_flush();
        test_tags();
        test_pc_wrap();
`ifdef FDQ_BYPASS_EN
        test_bypass();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_decode_queue.md
FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; power of two, range 4..32.
REQ-002 Parameter LANES, default 2, push/pop lanes per cycle; 1 or 2; DEPTH >= 2*LANES.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 flush  in  1  discard all entries (exception/branch redirect).
REQ-006 in_valid  in  LANES  per-lane push request, contiguous from lane 0.
REQ-007 in_pc  in  32*LANES  lane PCs.
REQ-008 in_instr  in  32*LANES  lane instructions.
REQ-009 in_ds  in  LANES  lane is in a branch delay slot.
REQ-010 in_excp  in  LANES  fetch exception (AdEL) tag.
REQ-011 in_ready  out  1  queue accepts a full LANES-wide push this cycle.
REQ-012 out_valid  out  LANES  head entries present, contiguous from lane 0.
REQ-013 out_pc, out_pc_plus4, out_instr  out  32*LANES each  head entry fields; pc_plus4 = pc + 4, modulo 2^32.
REQ-014 out_ds, out_excp  out  LANES each  head entry tags.
REQ-015 pop_cnt  in  clog2(LANES+1)  number of head entries consumed this cycle.
REQ-016 count  out  clog2(DEPTH+1)  current occupancy.

Function
REQ-017 Circular buffer; head/tail pointers clog2(DEPTH) bits, wrap modulo DEPTH.
REQ-018 in_ready = (DEPTH - count >= LANES), from registered count only; pop_cnt not considered (no combinational ready path).
REQ-019 Push: when in_ready=1, each set in_valid lane is written at tail+lane in lane order; tail advances by popcount(in_valid).
REQ-020 in_valid while in_ready=0: ignored, no state change.
REQ-021 Non-contiguous in_valid (e.g. 2'b10): illegal; write nothing.
REQ-022 Pop: head advances by pop_cnt; pop_cnt > popcount(out_valid) is illegal; the block clamps to popcount(out_valid).
REQ-023 Simultaneous push and pop: count_next = count + pushed - popped; both take effect in the same cycle.
REQ-024 out lane i is valid iff count > i; lane i shows entry at head+i (wrapped).
REQ-025 Latency: pushed entry visible on out_* the cycle after push (bypass disabled).
REQ-026 flush=1: head, tail, count cleared next cycle; push and pop in the same cycle discarded; flush dominates.
REQ-027 Invalid out lanes drive pc/instr/ds/excp as 0 (instr 0 = sll nop).
REQ-028 Delay-slot and exception tags travel unmodified with their entry; ordering strictly FIFO.

Reset
REQ-029 rst=0 at a rising edge: count=0, head=tail=0, out_valid=0, in_ready=1; storage contents need no reset.
REQ-030 Reset mid-operation discards all entries; rst has priority over flush, push and pop.

Configuration
REQ-031 Macro FDQ_BYPASS_EN defined: when count=0 and no flush, in_* lanes appear combinationally on out_* in the same cycle; pop_cnt may consume them, and consumed lanes are not written.
REQ-032 FDQ_BYPASS_EN undefined: no in-to-out combinational path; REQ-025 latency applies.

Structure
REQ-033 Shared package holds: the queue entry struct (pc, instr, ds, excp), the NOP_INSTR constant (32'h0) and the default DEPTH/LANES constants.
REQ-034 One sub-module, fdq_ptr, holds the wrapped pointer advance-by-N logic and is instantiated for head and tail.

Verification
REQ-035 Reset, then push lanes {pc 0xBFC00000, 0xBFC00004}, pop_cnt=0 -> next cycle out_valid=2'b11, out_pc_plus4 lane0=0xBFC00004, count=2.
REQ-036 Fill DEPTH=8, LANES=2 to count=7 -> in_ready=0; a push that cycle is ignored; pop_cnt=2 -> count=5, in_ready=1.
REQ-037 Push 2 and pop 2 every cycle across 12 cycles -> head/tail wrap past 7, FIFO order preserved, count stays constant.
REQ-038 count=4, flush=1 with a simultaneous push and pop_cnt=1 -> next cycle count=0, out_valid=0, out_instr=0.
REQ-039 Push lane1 with in_ds=1, in_excp=1 at pc 0x80000008 -> emerges at out lane with ds=1, excp=1 and correct pc after earlier entries pop.
REQ-040 With FDQ_BYPASS_EN, empty queue, push 2 and pop_cnt=2 in the same cycle -> out_valid=2'b11 that cycle and count=0 next cycle.
